point_encode: RTL and testbench
===============================

Name: point_encode

Overview:
Converts an extended/projective Edwards25519 point (X:Y:Z) into its affine coordinates and its 256-bit RFC 8032 compressed encoding.
- Computes Zi = Z^(p-2) mod p by constant-time right-to-left square-and-multiply.
- Computes x = X·Zi and y = Y·Zi.
- Packs enc = {x[0], y[254:0]}.
- Sits after point_double/point_add results in the signing/verification datapath, feeding the hash/compare stages.

Parameters:
EXP_BITS, 255, number of exponent bits scanned by the inversion loop (exponent constant INV_EXP = MODULUS-2 comes from parameters_pkg).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
X1  input  DATA_WIDTH  projective X, canonical value in [0, p)
Y1  input  DATA_WIDTH  projective Y, canonical
Z1  input  DATA_WIDTH  projective Z, canonical
x_aff  output  DATA_WIDTH  affine x
y_aff  output  DATA_WIDTH  affine y
enc  output  256  compressed encoding, bit 255 = x_aff[0], bits 254:0 = y_aff[254:0]
z_zero  output  1  error flag: Z1 was 0; valid with done
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse; outputs valid from that cycle until the next accepted start

Behaviour:
- Reset: state IDLE; done=0, busy=0, z_zero=0, x_aff=0, y_aff=0, enc=0. All mul_mont start strobes are 0.
- Reset asserted mid-operation aborts at the next edge. No done pulse is produced. In-flight mul_mont results are ignored; a new start is accepted once rst deasserts.
- Inputs are latched on the accepted start. Later input changes have no effect.
- start while busy is ignored.
- Arithmetic: two mul_mont instances, each returning a·b mod p canonical. Starts are one-cycle pulses. The FSM waits on each instance's done.
- States:
  - IDLE: on start, latch inputs; base←Z1, acc←1, bit index i←0; z_zero←(Z1==0); busy←1 → INV_ISSUE.
  - INV_ISSUE: mul1 ← base·base; mul2 ← acc·base; pulse both starts → INV_WAIT.
  - INV_WAIT: when both done:
    - base←mul1 result.
    - acc←mul2 result if INV_EXP[i]==1, else acc unchanged.
    - i←i+1.
    - If i==EXP_BITS-1 → AFF_ISSUE, else → INV_ISSUE.
  - AFF_ISSUE: mul1 ← X·acc; mul2 ← Y·acc; pulse both starts → AFF_WAIT.
  - AFF_WAIT: when both done → PACK.
  - PACK:
    - x_aff, y_aff ← results; enc ← {x[0], y[254:0]}.
    - done←1 for one cycle; busy←0 → IDLE.
    - done deasserts in the following cycle.
- Constant time: both multiplies are issued on every iteration regardless of the exponent bit; only the register write is conditional. Total latency is independent of the Z value, including Z=0.
- Z1=0 runs the full loop, so acc=0 and x_aff=y_aff=0. Then enc=0 and z_zero=1.
- If both multiplier dones arrive in different cycles, the first one is held in a per-instance sticky flag until the pair is complete. Sticky flags clear on each issue.
- Latency = 2 + EXP_BITS·(L_mul+2) + (L_mul+2) cycles from start to done, where L_mul is the mul_mont latency. The bench measures this and requires the same value for every input.

Decomposition:
- parameters_pkg (existing) gains:
  - INV_EXP = MODULUS-2
  - ENC_WIDTH = 256
  - enc_state_t enum {IDLE, INV_ISSUE, INV_WAIT, AFF_ISSUE, AFF_WAIT, PACK}
- DATA_WIDTH and MODULUS are reused from the package.
- One natural sub-module: mod_inv, holding the exponentiation loop with its own start/done. point_encode instantiates it and then performs the affine multiplies with a single shared mul_mont pair.
- mul_mont is reused unchanged.

Test Plan:
- Identity: X1=0, Y1=1, Z1=1 → x_aff=0, y_aff=1, enc=1, z_zero=0, one done pulse.
- Base point:
  - Stimulus: X1=Bx=15112221349535400772501151409588531511454012693041857206046113283949847762202, Y1=By=46316835694926478169428394003475163141307993866256225615783033603165251855960, Z1=1.
  - Required: enc=By (bit255=0, since Bx is even), x_aff=Bx.
- Scaled base point: X1=2·Bx mod p, Y1=2·By mod p, Z1=2 → identical outputs to the base-point case, identical latency.
- Negated base point: X1=p−Bx, Y1=By, Z1=1 → enc=By | 2^255.
- Z1=0 with X1=5, Y1=7 → z_zero=1, enc=0, x_aff=y_aff=0, same latency as the other cases.
- Control: a second start mid-run is ignored. rst is asserted at iteration 100 → no done, busy=0, outputs reset. The next start with the base-point inputs completes correctly.

Source files
------------

// File: rtl/parameters_pkg.sv
// rtl/parameters_pkg.sv - shared widths, field constants and encoder state type
// Contents:
//   DATA_WIDTH, MODULUS : field element width and p = 2^255-19
//   INV_EXP             : p-2, exponent for Fermat inversion
//   ENC_WIDTH           : compressed point width
//   FOLD_BITS, FOLD_C   : 2^255 == 19 (mod p), used by the multiplier reduction
//   MUL_DIGIT(S)        : multiplier digit size / digit count, MUL_LAT its start-to-done latency
//   enc_state_t         : point encoder / inverter state encoding
package parameters_pkg;

   localparam int DATA_WIDTH = 256;
   localparam logic [DATA_WIDTH-1:0] MODULUS =
      256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
   localparam logic [DATA_WIDTH-1:0] INV_EXP = MODULUS - 256'd2;
   localparam int ENC_WIDTH = 256;

   localparam int FOLD_BITS = 255;
   localparam int FOLD_C    = 19;

   localparam int MUL_DIGIT  = 16;
   localparam int MUL_DIGITS = DATA_WIDTH / MUL_DIGIT;
   localparam int MUL_LAT    = MUL_DIGITS + 1;

   typedef enum logic [2:0] {
      IDLE,
      INV_ISSUE,
      INV_WAIT,
      AFF_ISSUE,
      AFF_WAIT,
      PACK
   } enc_state_t;

endpackage

// File: rtl/mod_inv.sv
// rtl/mod_inv.sv - constant-time Z^(p-2) mod p, right-to-left square-and-multiply
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, z               : one-cycle request and canonical input, sampled in IDLE
//   mul1_* / mul2_*        : request side of the shared multiplier pair
//                            (mul1 squares base, mul2 multiplies acc by base)
//   mul1_done/result, mul2_done/result : multiplier responses
//   result                 : inverse (0 when z == 0), valid from the cycle after done
//   done                   : one-cycle pulse in the cycle the final product pair lands
module mod_inv
   import parameters_pkg::*;
#(
   parameter int EXP_BITS = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] z,
   output logic                  mul1_start,
   output logic [DATA_WIDTH-1:0] mul1_a,
   output logic [DATA_WIDTH-1:0] mul1_b,
   output logic                  mul2_start,
   output logic [DATA_WIDTH-1:0] mul2_a,
   output logic [DATA_WIDTH-1:0] mul2_b,
   input  logic                  mul1_done,
   input  logic [DATA_WIDTH-1:0] mul1_result,
   input  logic                  mul2_done,
   input  logic [DATA_WIDTH-1:0] mul2_result,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  done
);

   enc_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] base_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [7:0]            idx_q;
   logic                  sticky1_q, sticky2_q;
   logic                  pair_done;
   logic                  last;

   assign mul1_a = base_q;
   assign mul1_b = base_q;
   assign mul2_a = acc_q;
   assign mul2_b = base_q;
   assign result = acc_q;

   always_comb begin
      state_d   = state_q;
      pair_done = (mul1_done | sticky1_q) & (mul2_done | sticky2_q);
      last      = (idx_q == 8'(EXP_BITS - 1));
      done      = 1'b0;
      case (state_q)
         IDLE:      if (start) state_d = INV_ISSUE;
         INV_ISSUE: state_d = INV_WAIT;
         INV_WAIT: begin
            if (pair_done) begin
               state_d = last ? IDLE : INV_ISSUE;
               done    = last;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         acc_q      <= '0;
         idx_q      <= '0;
         sticky1_q  <= 1'b0;
         sticky2_q  <= 1'b0;
         mul1_start <= 1'b0;
         mul2_start <= 1'b0;
      end else begin
         state_q    <= state_d;
         mul1_start <= 1'b0;
         mul2_start <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  base_q <= z;
                  acc_q  <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                  idx_q  <= '0;
               end
            end
            INV_ISSUE: begin
               // Both products are issued every iteration so timing never
               // depends on the exponent bit.
               mul1_start <= 1'b1;
               mul2_start <= 1'b1;
               sticky1_q  <= 1'b0;
               sticky2_q  <= 1'b0;
            end
            INV_WAIT: begin
               if (mul1_done) sticky1_q <= 1'b1;
               if (mul2_done) sticky2_q <= 1'b1;
               if (pair_done) begin
                  base_q <= mul1_result;
                  if (INV_EXP[idx_q]) acc_q <= mul2_result;
                  idx_q <= idx_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mul_mont.sv
// rtl/mul_mont.sv - digit-serial a*b mod p multiplier, canonical result
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle request, ignored while a product is in flight
//   a, b          : canonical operands in [0, p), sampled with start
//   result        : a*b mod p, canonical, held until the next product completes
//   done          : one-cycle pulse, MUL_LAT cycles after the start cycle
module mul_mont
   import parameters_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  done
);

   localparam int TW = DATA_WIDTH + MUL_DIGIT;

   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [3:0]            cnt_q;
   logic                  run_q;

   logic [MUL_DIGIT-1:0]      digit;
   logic [TW-1:0]             t;
   logic [TW-FOLD_BITS-1:0]   hi;
   logic [DATA_WIDTH-1:0]     u;
   logic [DATA_WIDTH-1:0]     u2;
   logic [DATA_WIDTH-1:0]     red;

   // Horner step, MSB digit first: acc = acc*2^16 + a*digit, then fold the
   // bits above 2^255 back in as *19 twice and finish with one conditional
   // subtract, which keeps acc canonical every step.
   always_comb begin
      digit = b_q[DATA_WIDTH-1 -: MUL_DIGIT];
      t     = {acc_q, {MUL_DIGIT{1'b0}}}
            + ({{MUL_DIGIT{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, digit});
      hi    = t[TW-1:FOLD_BITS];
      u     = {1'b0, t[FOLD_BITS-1:0]}
            + (DATA_WIDTH'(hi) * DATA_WIDTH'(FOLD_C));
      u2    = {1'b0, u[FOLD_BITS-1:0]}
            + (u[FOLD_BITS] ? DATA_WIDTH'(FOLD_C) : {DATA_WIDTH{1'b0}});
      red   = (u2 >= MODULUS) ? (u2 - MODULUS) : u2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !run_q) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
         end else if (run_q) begin
            acc_q <= red;
            b_q   <= b_q << MUL_DIGIT;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'(MUL_DIGITS - 1)) begin
               run_q  <= 1'b0;
               result <= red;
               done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/point_encode.sv
// rtl/point_encode.sv - projective Edwards25519 point to affine x/y and compressed encoding
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle request, sampled only in IDLE
//   X1, Y1, Z1    : projective coordinates, canonical, latched on accepted start
//   x_aff, y_aff  : affine coordinates
//   enc           : {x_aff[0], y_aff[254:0]}
//   z_zero        : Z1 was zero (outputs are then all zero)
//   busy          : high from accepted start until done
//   done          : one-cycle pulse; outputs valid from then until the next start
module point_encode
   import parameters_pkg::*;
#(
   parameter int EXP_BITS = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] X1,
   input  logic [DATA_WIDTH-1:0] Y1,
   input  logic [DATA_WIDTH-1:0] Z1,
   output logic [DATA_WIDTH-1:0] x_aff,
   output logic [DATA_WIDTH-1:0] y_aff,
   output logic [ENC_WIDTH-1:0]  enc,
   output logic                  z_zero,
   output logic                  busy,
   output logic                  done
);

   enc_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] x_q, y_q;
   logic                  aff_start_q;
   logic                  sticky1_q, sticky2_q;
   logic                  pair_done;
   logic                  aff_sel;

   logic                  inv_start, inv_done;
   logic [DATA_WIDTH-1:0] inv_result;
   logic                  inv_m1_start, inv_m2_start;
   logic [DATA_WIDTH-1:0] inv_m1_a, inv_m1_b, inv_m2_a, inv_m2_b;

   logic                  m1_start, m2_start, m1_done, m2_done;
   logic [DATA_WIDTH-1:0] m1_a, m1_b, m2_a, m2_b, m1_result, m2_result;

   // The inverter owns the multiplier pair except while the affine products
   // are in flight; its own start is gated by IDLE so a start while busy
   // reaches neither FSM.
   always_comb begin
      inv_start = (state_q == IDLE) && start;
      aff_sel   = (state_q == AFF_WAIT);
      m1_start  = inv_m1_start | aff_start_q;
      m2_start  = inv_m2_start | aff_start_q;
      m1_a      = aff_sel ? x_q        : inv_m1_a;
      m1_b      = aff_sel ? inv_result : inv_m1_b;
      m2_a      = aff_sel ? y_q        : inv_m2_a;
      m2_b      = aff_sel ? inv_result : inv_m2_b;
      pair_done = (m1_done | sticky1_q) & (m2_done | sticky2_q);
   end

   mod_inv #(
      .EXP_BITS (EXP_BITS)
   ) u_inv (
      .clk         (clk),
      .rst         (rst),
      .start       (inv_start),
      .z           (Z1),
      .mul1_start  (inv_m1_start),
      .mul1_a      (inv_m1_a),
      .mul1_b      (inv_m1_b),
      .mul2_start  (inv_m2_start),
      .mul2_a      (inv_m2_a),
      .mul2_b      (inv_m2_b),
      .mul1_done   (m1_done),
      .mul1_result (m1_result),
      .mul2_done   (m2_done),
      .mul2_result (m2_result),
      .result      (inv_result),
      .done        (inv_done)
   );

   mul_mont u_mul1 (
      .clk    (clk),
      .rst    (rst),
      .start  (m1_start),
      .a      (m1_a),
      .b      (m1_b),
      .result (m1_result),
      .done   (m1_done)
   );

   mul_mont u_mul2 (
      .clk    (clk),
      .rst    (rst),
      .start  (m2_start),
      .a      (m2_a),
      .b      (m2_b),
      .result (m2_result),
      .done   (m2_done)
   );

   // The inversion iterations run inside mod_inv; this FSM steps from IDLE
   // straight to INV_WAIT and leaves INV_ISSUE to the inverter.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start) state_d = INV_WAIT;
         INV_WAIT:  if (inv_done) state_d = AFF_ISSUE;
         AFF_ISSUE: state_d = AFF_WAIT;
         AFF_WAIT:  if (pair_done) state_d = PACK;
         PACK:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         aff_start_q <= 1'b0;
         sticky1_q   <= 1'b0;
         sticky2_q   <= 1'b0;
         x_aff       <= '0;
         y_aff       <= '0;
         enc         <= '0;
         z_zero      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         aff_start_q <= 1'b0;
         done        <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  x_q    <= X1;
                  y_q    <= Y1;
                  z_zero <= (Z1 == '0);
                  busy   <= 1'b1;
               end
            end
            AFF_ISSUE: begin
               aff_start_q <= 1'b1;
               sticky1_q   <= 1'b0;
               sticky2_q   <= 1'b0;
            end
            AFF_WAIT: begin
               if (m1_done) sticky1_q <= 1'b1;
               if (m2_done) sticky2_q <= 1'b1;
            end
            PACK: begin
               x_aff <= m1_result;
               y_aff <= m2_result;
               enc   <= {m1_result[0], m2_result[FOLD_BITS-1:0]};
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_point_encode.sv
// tb/tb_point_encode.sv - directed vector bench for point_encode
module tb_point_encode;

   localparam logic [255:0] P  =
      256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
   localparam logic [255:0] BX =
      256'h216936D3_CD6E53FE_C0A4E231_FDD6DC5C_692CC760_9525A7B2_C9562D60_8F25D51A;
   localparam logic [255:0] BY =
      256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
   localparam int L_MUL   = 17;
   localparam int EXP_LAT = 2 + 255 * (L_MUL + 2) + (L_MUL + 2);
   localparam int LIMIT   = EXP_LAT + 200;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] X1, Y1, Z1;
   logic [255:0] x_aff, y_aff, enc;
   logic         z_zero, busy, done;

   int total = 0;
   int bad   = 0;

   point_encode dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .X1     (X1),
      .Y1     (Y1),
      .Z1     (Z1),
      .x_aff  (x_aff),
      .y_aff  (y_aff),
      .enc    (enc),
      .z_zero (z_zero),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [255:0] x1, y1, z1;
      logic [255:0] ex, ey, eenc;
      logic         ezz;
   } vec_t;

   vec_t vecs[7];

   function automatic vec_t mk(string n, logic [255:0] x1, logic [255:0] y1, logic [255:0] z1,
                               logic [255:0] ex, logic [255:0] ey, logic [255:0] eenc, logic ezz);
      vec_t v;
      v.name = n; v.x1 = x1; v.y1 = y1; v.z1 = z1;
      v.ex = ex; v.ey = ey; v.eenc = eenc; v.ezz = ezz;
      return v;
   endfunction

   function automatic logic [255:0] dbl_mod(logic [255:0] v);
      logic [256:0] t;
      t = {v, 1'b0};
      if (t >= {1'b0, P}) t = t - {1'b0, P};
      return t[255:0];
   endfunction

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Start one operation and wait (bounded) for done; lat counts from the
   // start cycle to the done cycle. Inputs are scrambled after the start
   // cycle to show they were latched.
   task automatic run_op(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                         output int lat);
      @(negedge clk);
      X1 = x; Y1 = y; Z1 = z; start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            start = 1'b0;
            X1 = y; Y1 = x; Z1 = '0;
         end
      end while (!done && lat < LIMIT);
   endtask

   initial begin
      int lat;
      int dones;
      rst = 1'b1; start = 1'b0; X1 = '0; Y1 = '0; Z1 = '0;

      vecs[0] = mk("identity", 256'd0, 256'd1, 256'd1, 256'd0, 256'd1, 256'd1, 1'b0);
      vecs[1] = mk("base", BX, BY, 256'd1, BX, BY, BY, 1'b0);
      vecs[2] = mk("scaled", dbl_mod(BX), dbl_mod(BY), 256'd2, BX, BY, BY, 1'b0);
      vecs[3] = mk("negated", P - BX, BY, 256'd1, P - BX, BY, BY | (256'd1 << 255), 1'b0);
      vecs[4] = mk("z_zero", 256'd5, 256'd7, 256'd0, 256'd0, 256'd0, 256'd0, 1'b1);
      vecs[5] = mk("small", 256'd6, 256'd9, 256'd3, 256'd2, 256'd3, 256'd3, 1'b0);
      vecs[6] = mk("z_minus1", 256'd3, 256'd4, P - 256'd1, P - 256'd3, P - 256'd4, P - 256'd4, 1'b0);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_done", {255'd0, done}, 256'd0);
      check("rst_busy", {255'd0, busy}, 256'd0);
      check("rst_zz", {255'd0, z_zero}, 256'd0);
      check("rst_x", x_aff, 256'd0);
      check("rst_y", y_aff, 256'd0);
      check("rst_enc", enc, 256'd0);

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].x1, vecs[i].y1, vecs[i].z1, lat);
         check({vecs[i].name, "_lat"}, 256'(lat), 256'(EXP_LAT));
         check({vecs[i].name, "_done"}, {255'd0, done}, 256'd1);
         check({vecs[i].name, "_busy"}, {255'd0, busy}, 256'd0);
         check({vecs[i].name, "_x"}, x_aff, vecs[i].ex);
         check({vecs[i].name, "_y"}, y_aff, vecs[i].ey);
         check({vecs[i].name, "_enc"}, enc, vecs[i].eenc);
         check({vecs[i].name, "_zz"}, {255'd0, z_zero}, {255'd0, vecs[i].ezz});
         @(negedge clk);
         check({vecs[i].name, "_pulse"}, {255'd0, done}, 256'd0);
         check({vecs[i].name, "_hold"}, enc, vecs[i].eenc);
      end

      // A second start mid-run must be ignored.
      @(negedge clk);
      X1 = BX; Y1 = BY; Z1 = 256'd1; start = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         start = 1'b0;
         if (lat == 50) begin
            check("mid_busy", {255'd0, busy}, 256'd1);
            X1 = 256'd5; Y1 = 256'd7; Z1 = 256'd0; start = 1'b1;
         end
      end while (!done && lat < LIMIT);
      check("mid_lat", 256'(lat), 256'(EXP_LAT));
      check("mid_x", x_aff, BX);
      check("mid_enc", enc, BY);
      check("mid_zz", {255'd0, z_zero}, 256'd0);
      @(negedge clk);
      check("mid_pulse", {255'd0, done}, 256'd0);

      // Reset at inversion iteration 100 aborts with no done.
      @(negedge clk);
      X1 = 256'd3; Y1 = 256'd4; Z1 = 256'd0; start = 1'b1;
      lat = 0;
      dones = 0;
      do begin
         @(negedge clk);
         lat++;
         start = 1'b0;
         if (done) dones++;
      end while (lat < 1 + 19 * 100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {255'd0, busy}, 256'd0);
      check("abort_done", {255'd0, done}, 256'd0);
      check("abort_x", x_aff, 256'd0);
      check("abort_y", y_aff, 256'd0);
      check("abort_enc", enc, 256'd0);
      check("abort_zz", {255'd0, z_zero}, 256'd0);
      for (int c = 0; c < EXP_LAT + 20; c++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", 256'(dones), 256'd0);

      run_op(BX, BY, 256'd1, lat);
      check("after_lat", 256'(lat), 256'(EXP_LAT));
      check("after_x", x_aff, BX);
      check("after_y", y_aff, BY);
      check("after_enc", enc, BY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
